// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-file dump reader.
// REG_DUMP_CHECKSUM_EN adds the SUM state used to emit a trailing checksum word.
package reg_dump_reader_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND    = 3'd2,
    DONE    = 3'd3
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    SUM     = 3'd4
`endif
  } dumpState_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks register indices 0..NUM_REGS-1 on the read-select port and streams each captured word.
// Optional REG_DUMP_CHECKSUM_EN appends a modulo-2^DATA_W sum of all captured words.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned IDX_W    = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  sr_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dumpState_t       state;
  dumpState_t       stateNext;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             atLast;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  // out_valid is only ever high in SEND/SUM, so this is the stream handshake
  assign xfer   = out_valid & out_ready;
  assign atLast = (idx == IDX_W'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = CAPTURE;
      CAPTURE: stateNext = SEND;
      SEND: begin
        if (xfer) begin
          if (atLast) begin
`ifdef REG_DUMP_CHECKSUM_EN
            stateNext = SUM;
`else
            stateNext = DONE;
`endif
          end else begin
            stateNext = CAPTURE;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SUM:     if (xfer) stateNext = DONE;
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Index walk, capture and stream registers; sr_sel tracks idx so it is valid in CAPTURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      sr_sel    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            sr_sel <= '0;
            busy   <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            sum    <= '0;
`endif
          end
        end
        CAPTURE: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          sum       <= sum + rd_data;
`else
          out_last  <= atLast;
`endif
        end
        SEND: begin
          if (xfer) begin
            if (atLast) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Checksum word reuses the final index and closes the dump
              out_data <= sum;
              out_idx  <= idx;
              out_last <= 1'b1;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              idx       <= '0;
              sr_sel    <= '0;
`endif
            end else begin
              idx       <= idx + IDX_W'(1);
              sr_sel    <= idx + IDX_W'(1);
              out_valid <= 1'b0;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        SUM: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            idx       <= '0;
            sr_sel    <= '0;
          end
        end
`endif
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
